elbeth_mux4b_arbiter: RTL and testbench

//  Two-requester round-robin arbiter that shares one 4-bit 2:1 datapath mux

---
 rtl/elbeth_mux4b_arbiter.sv | 114 +++++++++++
 tb/tb_elbeth_mux4b_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/elbeth_mux4b_arbiter.sv
// Two-requester round-robin arbiter that owns a shared 4-bit 2:1 mux.
// It grants one side at a time, drives bit_select, and registers the selected
// nibble onto mux_out with out_valid. A hold limit bounds one side's tenure
// while the other side is waiting.
module elbeth_mux4b_arbiter #(
    parameter int MAX_HOLD = 8      // legal range 1..15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_1,
    input  logic       req_2,
    input  logic [3:0] mux_in_1,
    input  logic [3:0] mux_in_2,
    output logic       gnt_1,
    output logic       gnt_2,
    output logic       bit_select,
    output logic [3:0] mux_out,
    output logic       out_valid
);

    typedef enum logic [1:0] {IDLE, G1, G2} state_t;

    localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

    state_t     state_q, state_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;
    logic       last_q, last_d;          // 0 = requester 1 served last, 1 = requester 2
    logic       bit_select_q, bit_select_d;
    logic [3:0] mux_out_q, mux_out_d;
    logic       out_valid_q, out_valid_d;

    // Next-state arbitration: tie-break by last owner, hand off directly on expiry
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (req_1 && req_2)  state_d = last_q ? G1 : G2;
                else if (req_1)      state_d = G1;
                else if (req_2)      state_d = G2;
            end
            G1: begin
                if (!req_1 || (hold_cnt_q == MAX_HOLD_C && req_2)) begin
                    last_d  = 1'b0;
                    state_d = req_2 ? G2 : IDLE;
                end
            end
            G2: begin
                if (!req_2 || (hold_cnt_q == MAX_HOLD_C && req_1)) begin
                    last_d  = 1'b1;
                    state_d = req_1 ? G1 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Tenure counter: 1 on a fresh grant, saturating while the grant stays
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (state_d == IDLE)
            hold_cnt_d = 4'd0;
        else if (state_d != state_q)
            hold_cnt_d = 4'd1;
        else if (hold_cnt_q < MAX_HOLD_C)
            hold_cnt_d = hold_cnt_q + 4'd1;
    end

    // Select follows the next grant so it lines up with gnt; it keeps its value in IDLE
    always_comb begin
        bit_select_d = bit_select_q;
        if (state_d == G2)      bit_select_d = 1'b1;
        else if (state_d == G1) bit_select_d = 1'b0;
    end

    // Transfer only when the current owner is still requesting
    always_comb begin
        mux_out_d   = mux_out_q;
        out_valid_d = 1'b0;
        if (state_q == G1 && req_1) begin
            mux_out_d   = mux_in_1;
            out_valid_d = 1'b1;
        end else if (state_q == G2 && req_2) begin
            mux_out_d   = mux_in_2;
            out_valid_d = 1'b1;
        end
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            hold_cnt_q   <= 4'd0;
            last_q       <= 1'b1;
            bit_select_q <= 1'b0;
            mux_out_q    <= 4'h0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            last_q       <= last_d;
            bit_select_q <= bit_select_d;
            mux_out_q    <= mux_out_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign gnt_1      = (state_q == G1);
    assign gnt_2      = (state_q == G2);
    assign bit_select = bit_select_q;
    assign mux_out    = mux_out_q;
    assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_elbeth_mux4b_arbiter.sv
// Directed bench for elbeth_mux4b_arbiter plus a randomized invariant sweep.
module tb_elbeth_mux4b_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_1 = 1'b0, req_2 = 1'b0;
    logic [3:0] mux_in_1 = 4'h0, mux_in_2 = 4'h0;
    logic       gnt_1, gnt_2, bit_select, out_valid;
    logic [3:0] mux_out;

    int n_chk = 0;
    int n_pass = 0;

    elbeth_mux4b_arbiter #(.MAX_HOLD(8)) dut (
        .clk(clk), .rst_n(rst_n), .req_1(req_1), .req_2(req_2),
        .mux_in_1(mux_in_1), .mux_in_2(mux_in_2),
        .gnt_1(gnt_1), .gnt_2(gnt_2), .bit_select(bit_select),
        .mux_out(mux_out), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // advance one clock; outputs are sampled and inputs driven 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_1 = 1'b0;
        req_2 = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    logic [3:0] exp_out;
    logic       owner1;

    initial begin
        // ---- reset values ----
        do_reset();
        chk("rst_gnt1", gnt_1, 0);
        chk("rst_gnt2", gnt_2, 0);
        chk("rst_bsel", bit_select, 0);
        chk("rst_mout", mux_out, 0);
        chk("rst_oval", out_valid, 0);

        // ---- 1: asynchronous reset mid-G2 ----
        req_2 = 1'b1; mux_in_2 = 4'h5;
        tick();
        chk("t1_g2", gnt_2, 1);
        tick();
        chk("t1_oval", out_valid, 1);
        chk("t1_mout", mux_out, 4'h5);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_async_gnt2", gnt_2, 0);
        chk("t1_async_bsel", bit_select, 0);
        chk("t1_async_mout", mux_out, 0);
        chk("t1_async_oval", out_valid, 0);
        req_1 = 1'b1; req_2 = 1'b1;
        #3 rst_n = 1'b1;
        tick();
        chk("t1_rel_gnt1", gnt_1, 1);
        chk("t1_rel_gnt2", gnt_2, 0);

        // ---- 2: solo requester 1 ----
        do_reset();
        req_1 = 1'b1; mux_in_1 = 4'hA;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk($sformatf("t2_gnt1_c%0d", i), gnt_1, 1);
            chk($sformatf("t2_oval_c%0d", i), out_valid, (i >= 2) ? 1 : 0);
            if (i >= 2) chk($sformatf("t2_mout_c%0d", i), mux_out, 4'hA);
            chk($sformatf("t2_bsel_c%0d", i), bit_select, 0);
        end
        req_1 = 1'b0;
        tick();
        chk("t2_idle_gnt1", gnt_1, 0);
        chk("t2_idle_oval", out_valid, 0);
        chk("t2_idle_bsel", bit_select, 0);

        // ---- 3: tie and round-robin ----
        do_reset();
        req_1 = 1'b1; req_2 = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("t3_gnt1_c%0d", i), gnt_1, 1);
        end
        req_1 = 1'b0;
        tick();
        chk("t3_handoff_gnt2", gnt_2, 1);
        chk("t3_handoff_gnt1", gnt_1, 0);
        chk("t3_handoff_bsel", bit_select, 1);
        chk("t3_handoff_oval", out_valid, 0);
        req_2 = 1'b0;
        tick();
        chk("t3_idle_a", {gnt_1, gnt_2}, 2'b00);
        req_1 = 1'b1; req_2 = 1'b1;           // last owner was 2 -> G1
        tick();
        chk("t3_tie2_gnt1", gnt_1, 1);
        req_1 = 1'b0; req_2 = 1'b0;
        tick();
        chk("t3_idle_b", {gnt_1, gnt_2}, 2'b00);
        req_1 = 1'b1; req_2 = 1'b1;           // last owner was 1 -> G2
        tick();
        chk("t3_tie3_gnt2", gnt_2, 1);
        chk("t3_tie3_bsel", bit_select, 1);
        req_1 = 1'b0; req_2 = 1'b0;
        tick();
        chk("t3_idle_c", {gnt_1, gnt_2}, 2'b00);
        chk("t3_idle_bsel_hold", bit_select, 1);

        // ---- 4: hold limit alternation ----
        do_reset();
        mux_in_1 = 4'h3; mux_in_2 = 4'hC;
        req_1 = 1'b1; req_2 = 1'b1;
        owner1 = 1'b1;
        for (int c = 1; c <= 32; c++) begin
            tick();
            chk($sformatf("t4_gnt1_c%0d", c), gnt_1, (((c - 1) / 8) % 2 == 0) ? 1 : 0);
            chk($sformatf("t4_gnt2_c%0d", c), gnt_2, (((c - 1) / 8) % 2 == 1) ? 1 : 0);
            if (c >= 2) begin
                exp_out = (((c - 2) / 8) % 2 == 0) ? 4'h3 : 4'hC;
                chk($sformatf("t4_oval_c%0d", c), out_valid, 1);
                chk($sformatf("t4_mout_c%0d", c), mux_out, exp_out);
            end
        end

        // ---- 5: saturation keeps the grant ----
        do_reset();
        req_1 = 1'b1; req_2 = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            chk($sformatf("t5_gnt1_c%0d", c), gnt_1, 1);
        end
        req_2 = 1'b1;
        tick();
        chk("t5_c21_gnt2", gnt_2, 1);
        chk("t5_c21_gnt1", gnt_1, 0);

        // ---- 6: random invariants ----
        do_reset();
        begin
            int v_excl = 0, v_bsel = 0, v_val = 0, v_mout = 0;
            logic p_g1 = 0, p_g2 = 0, p_r1 = 0, p_r2 = 0;
            logic [3:0] p_i1 = 0, p_i2 = 0, p_mout = 0;
            for (int c = 0; c < 10000; c++) begin
                req_1    = ($urandom_range(0, 3) != 0);
                req_2    = ($urandom_range(0, 3) != 0);
                mux_in_1 = 4'($urandom);
                mux_in_2 = 4'($urandom);
                p_g1 = gnt_1; p_g2 = gnt_2; p_r1 = req_1; p_r2 = req_2;
                p_i1 = mux_in_1; p_i2 = mux_in_2; p_mout = mux_out;
                tick();
                if (gnt_1 && gnt_2) v_excl++;
                if ((gnt_1 || gnt_2) && bit_select !== gnt_2) v_bsel++;
                if (p_g1 && p_r1) begin
                    if (out_valid !== 1'b1) v_val++;
                    if (mux_out !== p_i1) v_mout++;
                end else if (p_g2 && p_r2) begin
                    if (out_valid !== 1'b1) v_val++;
                    if (mux_out !== p_i2) v_mout++;
                end else begin
                    if (out_valid !== 1'b0) v_val++;
                    if (mux_out !== p_mout) v_mout++;
                end
            end
            chk("t6_excl_viol", 8'(v_excl), 0);
            chk("t6_bsel_viol", 8'(v_bsel), 0);
            chk("t6_oval_viol", 8'(v_val), 0);
            chk("t6_mout_viol", 8'(v_mout), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
